mod_req_queue: RTL and testbench
================================

Name: mod_req_queue

Overview:
Request-side front end for bus_controller's module (MOD_*) port.
- Accepts 128-bit line read/write requests from a cache client and buffers them in a small in-order FIFO.
- Presents one request at a time on MOD_EN/MOD_WR/MOD_A/MOD_WRITE_DATA and holds it until bus_controller completes it with MOD_R.
- Returns read data and the request tag to the client.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
TAGW, 2, client tag width
TIMEOUT, 255, cycles before an outstanding request is aborted (MOD_TIMEOUT_EN only)

Ports:
BUS_CLK  in  1  bus clock, all state on rising edge
RST  in  1  asynchronous active-low reset
REQ_V  in  1  client request valid
REQ_WR  in  1  1=write line, 0=read line
REQ_A  in  16  line address
REQ_WDATA  in  128  write data
REQ_TAG  in  TAGW  client tag, echoed on response
REQ_READY  out  1  queue can accept; push = REQ_V & REQ_READY
RSP_V  out  1  one-cycle response pulse
RSP_WR  out  1  response is for a write
RSP_TAG  out  TAGW  tag of completed request
RSP_RDATA  out  128  read data (0 for writes)
RSP_ERR  out  1  request aborted (timeout)
MOD_EN  out  1  request to bus_controller
MOD_WR  out  1  write qualifier
MOD_A  out  16  address
MOD_WRITE_DATA  out  128  write data
MOD_READ_DATA  in  128  read data, valid when MOD_R=1
MOD_R  in  1  one-cycle completion strobe from bus_controller
COUNT  out  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset (RST=0, asynchronous): all outputs 0, except REQ_READY=1 one cycle after release. FIFO empty. FSM in IDLE. Pointers 0. RSP_* cleared.
- Reset mid-transaction: MOD_EN drops immediately. The in-flight request and all queued requests are discarded with no response.
- FIFO: circular, wr_ptr/rd_ptr wrap modulo DEPTH; full/empty from COUNT.
  - REQ_READY = (COUNT != DEPTH), from registered COUNT only. A full queue refuses a push even in a cycle that pops.
  - Simultaneous push and pop: COUNT unchanged.
- FSM, registered outputs:
  - IDLE: MOD_EN=0. If COUNT!=0, next state ISSUE.
  - ISSUE: MOD_EN=1; MOD_WR/MOD_A/MOD_WRITE_DATA = head entry, held stable. On MOD_R=1: capture MOD_READ_DATA (writes capture 0), pop the head, go to RESP.
  - RESP: RSP_V=1 for exactly one cycle with the captured tag, WR and data. MOD_EN=0 this cycle. Next state ISSUE if COUNT!=0, else IDLE.
- Latency:
  - Push in cycle N into an empty queue: MOD_EN=1 in cycle N+2.
  - MOD_R in cycle M: RSP_V in cycle M+1.
  - Minimum MOD_EN deassertion between back-to-back requests is 1 cycle.
- Ordering: strictly FIFO; exactly one outstanding request.
- MOD_R while not in ISSUE: ignored, no state change.
- MOD_WRITE_DATA is driven 0 when MOD_WR=0.
- RSP_ERR is 0 unless MOD_TIMEOUT_EN.

Optional Feature:
MOD_TIMEOUT_EN
- Defined:
  - An 8-bit (clog2(TIMEOUT+1)) watchdog clears on entry to ISSUE and increments each ISSUE cycle.
  - When it reaches TIMEOUT with MOD_R still 0: drop MOD_EN, pop the head, go to RESP with RSP_ERR=1 and RSP_RDATA=0.
  - MOD_R in the same cycle as expiry wins: normal completion, RSP_ERR=0.
- Undefined: no counter; ISSUE waits indefinitely; RSP_ERR tied 0.

Decomposition:
- Package mod_bus_pkg: request struct {wr, addr[15:0], wdata[127:0], tag}, FSM state enum {IDLE, ISSUE, RESP}, MOD_AW=16, MOD_DW=128 constants.
- One sub-module: mod_req_fifo (parameterised circular FIFO with push/pop/count/full/empty). The FSM and response registers stay in mod_req_queue.

Test Plan:
- Single read: push rd A=16'h0040 tag 1. MOD_R after 3 cycles with data 128'hDEAD_BEEF. Required: MOD_EN high 3 cycles with MOD_A=0040, MOD_WR=0; RSP_V next cycle with tag 1 and RSP_RDATA=DEAD_BEEF.
- Fill/full: push 5 requests back-to-back with MOD_R held 0. Required: first 4 accepted, REQ_READY=0 after the 4th, COUNT=4, 5th held off. On first MOD_R, COUNT=3 and REQ_READY=1 next cycle.
- Order and wrap: 10 mixed rd/wr requests with tags 0..3 cycling. Required: MOD_A and RSP_TAG sequences match push order exactly; pointers wrap twice.
- Write: push wr A=16'h1230 data all-ones. Required: MOD_WR=1, MOD_WRITE_DATA all-ones, RSP_WR=1, RSP_RDATA=0.
- Async reset: assert RST mid-ISSUE between clock edges. Required: MOD_EN=0 immediately, COUNT=0, no RSP_V after release.
- MOD_TIMEOUT_EN, TIMEOUT=8: MOD_R never asserted. Required: MOD_EN high 8 cycles, then RSP_V with RSP_ERR=1 and the next entry issued. A second run with MOD_R on the expiry cycle gives RSP_ERR=0.

Source files
------------

// File: rtl/mod_bus_pkg.sv
// mod_bus_pkg: shared request type, FSM states and bus widths
// for the bus_controller module-port front end.
package mod_bus_pkg;

  localparam int MOD_AW   = 16;
  localparam int MOD_DW   = 128;
  localparam int MOD_TAGW = 2;

  typedef struct packed {
    logic                wr;
    logic [MOD_AW-1:0]   addr;
    logic [MOD_DW-1:0]   wdata;
    logic [MOD_TAGW-1:0] tag;
  } mod_req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } mod_state_t;

endpackage

// File: rtl/mod_req_fifo.sv
// mod_req_fifo: in-order circular request buffer; head is
// visible combinationally, count/full/empty from registered count.
module mod_req_fifo
  import mod_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  mod_req_t               din,
  output mod_req_t               head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  mod_req_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mod_req_queue.sv
// mod_req_queue: buffers client line requests and issues them one at a
// time to bus_controller. Optional watchdog: define MOD_TIMEOUT_EN.
module mod_req_queue
  import mod_bus_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAGW    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                   BUS_CLK,
  input  logic                   RST,
  input  logic                   REQ_V,
  input  logic                   REQ_WR,
  input  logic [MOD_AW-1:0]      REQ_A,
  input  logic [MOD_DW-1:0]      REQ_WDATA,
  input  logic [TAGW-1:0]        REQ_TAG,
  output logic                   REQ_READY,
  output logic                   RSP_V,
  output logic                   RSP_WR,
  output logic [TAGW-1:0]        RSP_TAG,
  output logic [MOD_DW-1:0]      RSP_RDATA,
  output logic                   RSP_ERR,
  output logic                   MOD_EN,
  output logic                   MOD_WR,
  output logic [MOD_AW-1:0]      MOD_A,
  output logic [MOD_DW-1:0]      MOD_WRITE_DATA,
  input  logic [MOD_DW-1:0]      MOD_READ_DATA,
  input  logic                   MOD_R,
  output logic [$clog2(DEPTH):0] COUNT
);

  mod_req_t   req;
  mod_req_t   head;
  mod_state_t state;
  logic       push;
  logic       done;
  logic       expire;
  logic       rdy_q;
  logic       full;
  logic       empty;

  assign req = '{
    wr:    REQ_WR,
    addr:  REQ_A,
    wdata: REQ_WDATA,
    tag:   MOD_TAGW'(REQ_TAG)
  };

  // rdy_q keeps REQ_READY low until the first edge after reset.
  assign REQ_READY = rdy_q & ~full;
  assign push      = REQ_V & REQ_READY;
  assign done      = (state == ISSUE) & (MOD_R | expire);

  mod_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (BUS_CLK),
    .rst_n (RST),
    .push  (push),
    .pop   (done),
    .din   (req),
    .head  (head),
    .count (COUNT),
    .full  (full),
    .empty (empty)
  );

`ifdef MOD_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [WDW-1:0] wd;

  // Expiry fires on the cycle the count would reach TIMEOUT.
  assign expire = (state == ISSUE) & ~MOD_R
                & (wd == WDW'(TIMEOUT - 1));

  always_ff @(posedge BUS_CLK or negedge RST) begin
    if (!RST)
      wd <= '0;
    else if (state != ISSUE)
      wd <= '0;
    else
      wd <= wd + 1'b1;
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge BUS_CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      rdy_q          <= 1'b0;
      MOD_EN         <= 1'b0;
      MOD_WR         <= 1'b0;
      MOD_A          <= '0;
      MOD_WRITE_DATA <= '0;
      RSP_V          <= 1'b0;
      RSP_WR         <= 1'b0;
      RSP_TAG        <= '0;
      RSP_RDATA      <= '0;
      RSP_ERR        <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      RSP_V <= 1'b0;
      unique case (state)
        IDLE, RESP: begin
          if (!empty) begin
            state          <= ISSUE;
            MOD_EN         <= 1'b1;
            MOD_WR         <= head.wr;
            MOD_A          <= head.addr;
            MOD_WRITE_DATA <= head.wr ? head.wdata : '0;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (done) begin
            state     <= RESP;
            MOD_EN    <= 1'b0;
            RSP_V     <= 1'b1;
            RSP_WR    <= head.wr;
            RSP_TAG   <= TAGW'(head.tag);
            RSP_ERR   <= ~MOD_R;
            RSP_RDATA <= (MOD_R & ~head.wr)
                       ? MOD_READ_DATA : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_req_queue.sv
// tb_mod_req_queue: directed self-checking bench for mod_req_queue.
// Timeout steps run only when MOD_TIMEOUT_EN is defined.
module tb_mod_req_queue;

  logic         BUS_CLK = 1'b0;
  logic         RST;
  logic         REQ_V;
  logic         REQ_WR;
  logic [15:0]  REQ_A;
  logic [127:0] REQ_WDATA;
  logic [1:0]   REQ_TAG;
  logic         REQ_READY;
  logic         RSP_V;
  logic         RSP_WR;
  logic [1:0]   RSP_TAG;
  logic [127:0] RSP_RDATA;
  logic         RSP_ERR;
  logic         MOD_EN;
  logic         MOD_WR;
  logic [15:0]  MOD_A;
  logic [127:0] MOD_WRITE_DATA;
  logic [127:0] MOD_READ_DATA;
  logic         MOD_R;
  logic [2:0]   COUNT;

  int checks = 0;
  int errors = 0;

  always #5 BUS_CLK = ~BUS_CLK;

  mod_req_queue #(
    .DEPTH   (4),
    .TAGW    (2),
    .TIMEOUT (8)
  ) dut (
    .BUS_CLK        (BUS_CLK),
    .RST            (RST),
    .REQ_V          (REQ_V),
    .REQ_WR         (REQ_WR),
    .REQ_A          (REQ_A),
    .REQ_WDATA      (REQ_WDATA),
    .REQ_TAG        (REQ_TAG),
    .REQ_READY      (REQ_READY),
    .RSP_V          (RSP_V),
    .RSP_WR         (RSP_WR),
    .RSP_TAG        (RSP_TAG),
    .RSP_RDATA      (RSP_RDATA),
    .RSP_ERR        (RSP_ERR),
    .MOD_EN         (MOD_EN),
    .MOD_WR         (MOD_WR),
    .MOD_A          (MOD_A),
    .MOD_WRITE_DATA (MOD_WRITE_DATA),
    .MOD_READ_DATA  (MOD_READ_DATA),
    .MOD_R          (MOD_R),
    .COUNT          (COUNT)
  );

  task automatic chk(input string tg,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tg, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge BUS_CLK);
  endtask

  task automatic push(input logic wr,
                      input logic [15:0] a,
                      input logic [127:0] wd,
                      input logic [1:0] tg);
    chk("push.ready", REQ_READY, 1);
    REQ_V = 1'b1; REQ_WR = wr; REQ_A = a;
    REQ_WDATA = wd; REQ_TAG = tg;
    tick();
    REQ_V = 1'b0;
  endtask

  task automatic wait_en(input string tg);
    for (int i = 0; i < 20; i++) begin
      if (MOD_EN) break;
      tick();
    end
    chk({tg, ".en"}, MOD_EN, 1);
  endtask

  task automatic serve(input string tg,
                       input logic [15:0] ea,
                       input logic ew,
                       input logic [127:0] wd,
                       input logic [1:0] et,
                       input logic [127:0] rd);
    wait_en(tg);
    chk({tg, ".a"}, MOD_A, ea);
    chk({tg, ".wr"}, MOD_WR, ew);
    chk({tg, ".wd"}, MOD_WRITE_DATA, ew ? wd : 128'h0);
    MOD_R = 1'b1; MOD_READ_DATA = rd;
    tick();
    MOD_R = 1'b0; MOD_READ_DATA = '0;
    chk({tg, ".rspv"}, RSP_V, 1);
    chk({tg, ".rspen"}, MOD_EN, 0);
    chk({tg, ".rsptag"}, RSP_TAG, et);
    chk({tg, ".rspwr"}, RSP_WR, ew);
    chk({tg, ".rdata"}, RSP_RDATA, ew ? 128'h0 : rd);
    chk({tg, ".err"}, RSP_ERR, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    logic [15:0] ea;
    logic [127:0] wd;

    RST = 1'b0; REQ_V = 1'b0; REQ_WR = 1'b0;
    REQ_A = '0; REQ_WDATA = '0; REQ_TAG = '0;
    MOD_R = 1'b0; MOD_READ_DATA = '0;
    tick(); tick();
    chk("rst.en", MOD_EN, 0);
    chk("rst.ready", REQ_READY, 0);
    chk("rst.count", COUNT, 0);
    chk("rst.rspv", RSP_V, 0);
    RST = 1'b1;
    tick();
    chk("rel.ready", REQ_READY, 1);

    // Single read: MOD_EN two cycles after the push, MOD_R on 3rd.
    push(1'b0, 16'h0040, 128'h0, 2'd1);
    chk("rd.count", COUNT, 1);
    chk("rd.en0", MOD_EN, 0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      chk("rd.en", MOD_EN, 1);
      chk("rd.a", MOD_A, 16'h0040);
      chk("rd.wr", MOD_WR, 0);
      if (k < 3) tick();
    end
    MOD_R = 1'b1; MOD_READ_DATA = 128'hDEAD_BEEF;
    tick();
    MOD_R = 1'b0; MOD_READ_DATA = '0;
    chk("rd.rspv", RSP_V, 1);
    chk("rd.tag", RSP_TAG, 1);
    chk("rd.rdata", RSP_RDATA, 128'hDEAD_BEEF);
    chk("rd.en_off", MOD_EN, 0);
    chk("rd.count0", COUNT, 0);
    tick();
    chk("rd.pulse", RSP_V, 0);
    chk("rd.idle", MOD_EN, 0);

    // Write line.
    push(1'b1, 16'h1230, {128{1'b1}}, 2'd2);
    serve("wr", 16'h1230, 1'b1, {128{1'b1}}, 2'd2,
          128'h5555);

    // Fill to full with MOD_R held low.
    for (int i = 0; i < 4; i++)
      push(1'b0, 16'h0100 + 16'(i), 128'h0, 2'(i));
    chk("full.count", COUNT, 4);
    chk("full.ready", REQ_READY, 0);
    REQ_V = 1'b1; REQ_WR = 1'b0; REQ_A = 16'h0104;
    REQ_WDATA = '0; REQ_TAG = 2'd0;
    tick(); tick();
    chk("full.hold", COUNT, 4);
    chk("full.en", MOD_EN, 1);
    chk("full.a0", MOD_A, 16'h0100);
    MOD_R = 1'b1; MOD_READ_DATA = 128'h77;
    tick();
    MOD_R = 1'b0;
    chk("full.pop", COUNT, 3);
    chk("full.ready1", REQ_READY, 1);
    chk("full.rspv", RSP_V, 1);
    chk("full.rdata", RSP_RDATA, 128'h77);
    tick();
    REQ_V = 1'b0;
    chk("full.push5", COUNT, 4);
    for (int i = 1; i < 5; i++)
      serve("fill", 16'h0100 + 16'(i), 1'b0, 128'h0,
            2'(i), 128'hB000 + 128'(i));

    // Ten mixed requests in batches, pointers wrap.
    for (int b = 0; b < 10; b += 4) begin
      for (int i = b; i < b + 4 && i < 10; i++) begin
        ea = 16'h2000 + 16'(i * 16);
        wd = {4{32'(i) + 32'hC0DE0000}};
        push(1'(i & 1), ea, wd, 2'(i));
      end
      for (int i = b; i < b + 4 && i < 10; i++) begin
        ea = 16'h2000 + 16'(i * 16);
        wd = {4{32'(i) + 32'hC0DE0000}};
        serve("ord", ea, 1'(i & 1), wd, 2'(i),
              128'hA000 + 128'(i));
      end
    end

    // Asynchronous reset mid-ISSUE.
    push(1'b0, 16'h3000, 128'h0, 2'd3);
    push(1'b0, 16'h3010, 128'h0, 2'd0);
    wait_en("arst");
    #2 RST = 1'b0;
    #1;
    chk("arst.en", MOD_EN, 0);
    chk("arst.count", COUNT, 0);
    @(negedge BUS_CLK);
    RST = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      MOD_R = (k == 2);
      tick();
      if (RSP_V || MOD_EN) bad++;
    end
    MOD_R = 1'b0;
    chk("arst.quiet", bad, 0);
    chk("arst.count0", COUNT, 0);
    chk("arst.ready", REQ_READY, 1);

`ifdef MOD_TIMEOUT_EN
    push(1'b0, 16'h4000, 128'h0, 2'd0);
    push(1'b0, 16'h4010, 128'h0, 2'd1);
    push(1'b0, 16'h4020, 128'h0, 2'd2);
    wait_en("to");
    n = 0;
    for (int k = 0; k < 30; k++) begin
      if (!MOD_EN) break;
      n++;
      tick();
    end
    chk("to.cycles", n, 8);
    chk("to.rspv", RSP_V, 1);
    chk("to.err", RSP_ERR, 1);
    chk("to.tag", RSP_TAG, 0);
    chk("to.rdata", RSP_RDATA, 0);
    tick();
    chk("to.next", MOD_EN, 1);
    chk("to.next_a", MOD_A, 16'h4010);
    for (int k = 1; k < 8; k++) tick();
    chk("to2.en", MOD_EN, 1);
    MOD_R = 1'b1; MOD_READ_DATA = 128'h1234;
    tick();
    MOD_R = 1'b0; MOD_READ_DATA = '0;
    chk("to2.rspv", RSP_V, 1);
    chk("to2.err", RSP_ERR, 0);
    chk("to2.tag", RSP_TAG, 1);
    chk("to2.rdata", RSP_RDATA, 128'h1234);
    serve("to3", 16'h4020, 1'b0, 128'h0, 2'd2, 128'h99);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
